// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the core and a debug requester
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_halt,
  output logic              halted,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic              dbg_req_we,
  input  logic [2:0]        dbg_req_funct3,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  input  logic [DATA_W-1:0] dbg_req_wdata,
  output logic              dbg_resp_valid,
  output logic [DATA_W-1:0] dbg_resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  typedef enum logic [1:0] {CORE, STEAL, HALT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic core_busy, dbg_sel, accept, blocked;
  // port steering: debug owns the port in STEAL/HALT or whenever the core is idle
  always_comb begin
    core_busy     = core_mem_read | core_mem_write;
    dbg_sel       = (state_q != CORE) | ~core_busy;
    dbg_req_ready = ~reset & dbg_sel;
    accept        = dbg_req_valid & dbg_req_ready;
    blocked       = (state_q == CORE) & dbg_req_valid & core_busy;
    mem_read      = ~reset & (dbg_sel ? dbg_req_valid & ~dbg_req_we : core_mem_read);
    mem_write     = ~reset & (dbg_sel ? dbg_req_valid & dbg_req_we : core_mem_write);
    mem_funct3    = dbg_sel ? dbg_req_funct3 : core_funct3;
    mem_addr      = dbg_sel ? dbg_req_addr : core_addr;
    mem_wdata     = dbg_sel ? dbg_req_wdata : core_wdata;
  end
  // halt wins everywhere; a steal lasts one cycle since debug is always ready in it
  always_comb begin
    state_d = dbg_halt ? HALT
            : (state_q == CORE && blocked && cnt_q == CW'(STARVE_LIMIT - 1)) ? STEAL
            : CORE;
    cnt_d   = (state_d != state_q || !dbg_req_valid || accept) ? '0 : cnt_q + CW'(blocked);
  end
  // state, starvation counter and the one-cycle response pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CORE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= accept;
      resp_rdata_q <= (accept & ~dbg_req_we) ? mem_rdata : '0;
    end
  end
  assign core_rdata     = mem_rdata;
  assign core_stall     = state_q != CORE;
  assign halted         = state_q == HALT;
  assign dbg_resp_valid = resp_valid_q;
  assign dbg_resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic against a behavioural arbiter model
module tb_dmem_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic core_mem_read = 1'b0, core_mem_write = 1'b0;
  logic [2:0] core_funct3 = 3'b010;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic dbg_halt = 1'b0, dbg_req_valid = 1'b0, dbg_req_we = 1'b0;
  logic [2:0] dbg_req_funct3 = 3'b010;
  logic [31:0] dbg_req_addr = '0, dbg_req_wdata = '0;
  logic [31:0] core_rdata, dbg_resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic core_stall, halted, dbg_req_ready, dbg_resp_valid, mem_read, mem_write;
  logic [2:0] mem_funct3;
  logic [31:0] u1_core_rdata, u1_resp_rdata, u1_mem_addr, u1_mem_wdata;
  logic u1_stall, u1_halted, u1_ready, u1_resp_valid, u1_mem_read, u1_mem_write;
  logic [2:0] u1_mem_funct3;
  logic [31:0] mem [32];
  logic [31:0] mem_m [32];
  bit mem_ready, m_init;
  logic m_halt = 1'b0, m_steal = 1'b0, m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  int m_wait = 0, dut_wait = 0;
  logic m_busy, m_st, m_ds, m_rdy, m_acc, m_blk, m_wr, m_rdn, m_nst, m_chg;
  logic [31:0] m_a, m_d;
  logic [2:0] m_f;
  logic stall_s = 1'b0, acc_s = 1'b0;
  int pc = 0;
  logic [1:0] prog_op [1024];
  logic [31:0] prog_a [1024], prog_d [1024];
  int n_chk = 0, n_err = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) u0 (
    .clk(clk), .reset(reset), .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_funct3(core_funct3), .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .dbg_halt(dbg_halt), .halted(halted), .dbg_req_valid(dbg_req_valid),
    .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we), .dbg_req_funct3(dbg_req_funct3),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata), .dbg_resp_valid(dbg_resp_valid),
    .dbg_resp_rdata(dbg_resp_rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(1)) u1 (
    .clk(clk), .reset(reset), .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_funct3(core_funct3), .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(u1_core_rdata),
    .core_stall(u1_stall), .dbg_halt(dbg_halt), .halted(u1_halted), .dbg_req_valid(dbg_req_valid),
    .dbg_req_ready(u1_ready), .dbg_req_we(dbg_req_we), .dbg_req_funct3(dbg_req_funct3),
    .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata), .dbg_resp_valid(u1_resp_valid),
    .dbg_resp_rdata(u1_resp_rdata), .mem_read(u1_mem_read), .mem_write(u1_mem_write), .mem_funct3(u1_mem_funct3),
    .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_rdata(32'd0));

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h01010101 * i;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[6:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_prog(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    prog_op[i & 1023] = op;
    prog_a[i & 1023] = a;
    prog_d[i & 1023] = d;
  endtask

  // one core instruction slot: the PC advances only past a non-stalled cycle
  task automatic cyc();
    @(posedge clk);
    #1;
    if (!stall_s) pc++;
    core_mem_read  = prog_op[pc & 1023] == 2'd1;
    core_mem_write = prog_op[pc & 1023] == 2'd2;
    core_addr      = prog_a[pc & 1023];
    core_wdata     = prog_d[pc & 1023];
  endtask

  // reference model: debug owns the port when the core is idle, halted, or owed a steal
  always @(negedge clk) begin
    if (!m_init) begin
      for (int i = 0; i < 32; i++) mem_m[i] = init_word(i);
      m_init = 1'b1;
    end
    m_busy = core_mem_read | core_mem_write;
    m_st   = m_halt | m_steal;
    m_ds   = m_st | !m_busy;
    m_rdy  = !reset && m_ds;
    m_acc  = dbg_req_valid && m_rdy;
    m_blk  = !reset && !m_st && dbg_req_valid && m_busy;
    m_wr   = !reset && (m_ds ? dbg_req_valid && dbg_req_we : core_mem_write);
    m_rdn  = !reset && (m_ds ? dbg_req_valid && !dbg_req_we : core_mem_read);
    m_a    = m_ds ? dbg_req_addr : core_addr;
    m_d    = m_ds ? dbg_req_wdata : core_wdata;
    m_f    = m_ds ? dbg_req_funct3 : core_funct3;
    chk("stall", core_stall, m_st);
    chk("halted", halted, m_halt);
    chk("ready", dbg_req_ready, m_rdy);
    chk("mem_write", mem_write, m_wr);
    chk("mem_read", mem_read, m_rdn);
    if (m_wr || m_rdn) begin
      chk("mem_addr", mem_addr, m_a);
      chk("mem_funct3", mem_funct3, m_f);
    end
    if (m_wr) chk("mem_wdata", mem_wdata, m_d);
    chk("core_rdata", core_rdata, mem_rdata);
    chk("resp_valid", dbg_resp_valid, m_rv);
    if (m_rv) chk("resp_rdata", dbg_resp_rdata, m_rd);
    stall_s = core_stall;
    acc_s   = dbg_req_valid && dbg_req_ready;
    if (reset) dut_wait = 0;
    else if (acc_s) begin
      chk("wait_bound", dut_wait <= LIM, 1);
      dut_wait = 0;
    end else dut_wait = dbg_req_valid ? dut_wait + 1 : 0;
    if (reset) begin
      m_halt = 1'b0; m_steal = 1'b0; m_wait = 0; m_rv = 1'b0; m_rd = '0;
    end else begin
      m_rv = m_acc;
      m_rd = (m_acc && !dbg_req_we) ? mem_m[dbg_req_addr[6:2]] : '0;
      if (m_wr) mem_m[m_a[6:2]] = m_d;
      m_nst  = m_blk && m_wait == LIM - 1 && !dbg_halt;
      m_chg  = (dbg_halt != m_halt) || (m_nst != m_steal);
      m_wait = (m_chg || !dbg_req_valid || m_acc) ? 0 : m_wait + int'(m_blk);
      m_halt  = dbg_halt;
      m_steal = m_nst;
    end
  end

  initial begin
    int p0, ps;
    bit found;
    logic [31:0] ra [3];
    logic [31:0] re [3];
    ra = '{32'h10, 32'h20, 32'h40};
    re = '{32'hDEADBEEF, 32'h12345678, 32'h11111111};
    for (int i = 0; i < 1024; i++) set_prog(i, 2'd0, '0, '0);
    dbg_req_valid = 1'b1;
    dbg_req_addr  = 32'h10;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", dbg_req_ready, 0);
      chk("rst_stall", core_stall, 0);
      chk("rst_halted", halted, 0);
      chk("rst_resp", dbg_resp_valid, 0);
    end
    cyc(); reset = 1'b0; dbg_req_valid = 1'b0;
    @(negedge clk); chk("idle_ready", dbg_req_ready, 1);
    cyc(); dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 32'h10;
    @(negedge clk); chk("t2_ready", dbg_req_ready, 1); chk("t2_stall", core_stall, 0);
    cyc(); dbg_req_valid = 1'b0;
    @(negedge clk);
    chk("t2_resp", dbg_resp_valid, 1); chk("t2_rdata", dbg_resp_rdata, 32'hDEADBEEF); chk("t2_stall2", core_stall, 0);
    for (int i = 1; i <= 20; i++) set_prog(pc + i, 2'd1, 32'h0, '0);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) begin
        dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 32'h20; dbg_req_wdata = 32'h12345678; p0 = pc;
      end
      if (c == 6) dbg_req_valid = 1'b0;
      @(negedge clk);
      if (c <= 4) begin
        chk("t3_stall", core_stall, 0); chk("t3_ready", dbg_req_ready, 0);
      end
      if (c == 1) chk("lim1_nostall", u1_stall, 0);
      if (c == 2) chk("lim1_steal", u1_stall, 1);
      if (c == 5) begin
        chk("t3_steal", core_stall, 1); chk("t3_mw", mem_write, 1); chk("t3_addr", mem_addr, 32'h20);
      end
      if (c == 6) begin
        chk("t3_unstall", core_stall, 0); chk("t3_ack", dbg_resp_valid, 1); chk("t3_ackdata", dbg_resp_rdata, 0);
        chk("t3_pc", pc, p0 + 4); chk("t3_mem", mem[8], 32'h12345678);
      end
    end
    set_prog(pc + 1, 2'd2, 32'h40, 32'hAAAA5555);
    for (int i = 2; i <= 20; i++) set_prog(pc + i, 2'd0, '0, '0);
    cyc(); dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 32'h40; dbg_req_wdata = 32'h11111111;
    @(negedge clk); chk("t4_ready", dbg_req_ready, 0); chk("t4_core_wd", mem_wdata, 32'hAAAA5555);
    cyc();
    @(negedge clk); chk("t4_ready2", dbg_req_ready, 1); chk("t4_dbg_wd", mem_wdata, 32'h11111111);
    cyc(); dbg_req_valid = 1'b0;
    @(negedge clk); chk("t4_ack", dbg_resp_valid, 1); chk("t4_mem", mem[16], 32'h11111111);
    set_prog(pc + 1, 2'd2, 32'h44, 32'h5A5A5A5A);
    cyc(); dbg_halt = 1'b1; ps = pc;
    @(negedge clk); chk("t5_sw", mem_write, 1); chk("t5_swaddr", mem_addr, 32'h44); chk("t5_nohalt", halted, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) begin
        dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = ra[k];
      end else dbg_req_valid = 1'b0;
      @(negedge clk);
      chk("t5_halted", halted, 1);
      if (k < 3) chk("t5_ready", dbg_req_ready, 1);
      if (k > 0) begin
        chk("t5_resp", dbg_resp_valid, 1); chk("t5_order", dbg_resp_rdata, re[k-1]);
      end
    end
    cyc(); dbg_halt = 1'b0;
    @(negedge clk); chk("t5_still", halted, 1);
    cyc();
    @(negedge clk); chk("t5_unhalt", halted, 0); chk("t5_pc", pc, ps + 1); chk("t5_mem", mem[17], 32'h5A5A5A5A);
    for (int i = 1; i <= 20; i++) set_prog(pc + i, 2'd1, 32'h0, '0);
    cyc(); dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_req_addr = 32'h10;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (core_stall) begin
        reset = 1'b1; found = 1'b1;
      end
    end
    chk("t6_steal_seen", found, 1);
    @(negedge clk); chk("t6_rst_ready", dbg_req_ready, 0); chk("t6_rst_mr", mem_read, 0);
    cyc(); reset = 1'b0; dbg_req_valid = 1'b0;
    @(negedge clk); chk("t6_stall", core_stall, 0); chk("t6_noresp", dbg_resp_valid, 0);
    for (int i = pc + 1; i < 1024; i++)
      set_prog(i, 2'($urandom_range(2, 0)), 32'($urandom_range(31, 0)) << 2, $urandom);
    repeat (400) begin
      cyc();
      if (!dbg_req_valid || acc_s) begin
        dbg_req_valid  = 1'($urandom_range(1, 0));
        dbg_req_we     = 1'($urandom_range(1, 0));
        dbg_req_funct3 = 3'($urandom_range(7, 0));
        dbg_req_addr   = 32'($urandom_range(31, 0)) << 2;
        dbg_req_wdata  = $urandom;
      end else if ($urandom_range(15, 0) == 0) dbg_req_valid = 1'b0;
      if ($urandom_range(19, 0) == 0) dbg_halt = ~dbg_halt;
    end
    for (int i = 1; i <= 10; i++) set_prog(pc + i, 2'd0, '0, '0);
    cyc(); dbg_halt = 1'b0; dbg_req_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    for (int i = 0; i < 32; i++) chk("mem_word", mem[i], mem_m[i]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
